// File: rtl/rpm_disp_pkg.sv
// Shared types and constants for the RPM LED display path: stage encodings,
// RGB colour codes, bar geometry and the live-bar helpers.
package rpm_disp_pkg;

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      CAUTION = 2'd1,
      DANGER  = 2'd2
   } stage_e;

   localparam logic [2:0] GREEN  = 3'b010;
   localparam logic [2:0] YELLOW = 3'b110;
   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] OFF    = 3'b000;

   localparam int unsigned BAR_SEGS = 5;
   localparam int unsigned TMR_W    = 12;

   // Segment k lights when s*5 >= k*m, so the bar fills proportionally to s/m.
   function automatic logic [BAR_SEGS-1:0] live_bar(input logic [3:0] s, input logic [3:0] m);
      logic [6:0]          p;
      logic [BAR_SEGS-1:0] b;
      p    = 7'(s) * 7'd5;
      b    = '0;
      b[0] = (s != 4'd0);
      for (int k = 1; k < BAR_SEGS; k++) begin
         b[k] = (p >= 7'(k) * 7'(m));
      end
      return b;
   endfunction

   function automatic logic [2:0] seg_count(input logic [BAR_SEGS-1:0] b);
      logic [2:0] n;
      n = '0;
      for (int k = 0; k < BAR_SEGS; k++) begin
         n = n + 3'(b[k]);
      end
      return n;
   endfunction

endpackage

// File: rtl/rpm_peak_hold.sv
// Peak-hold tracker for the bar: holds the highest live segment count, then
// decays it one segment at a time once the hold timer expires.
module rpm_peak_hold
   import rpm_disp_pkg::*;
#(
   parameter int unsigned PEAK_HOLD_CYCLES  = 1000,
   parameter int unsigned PEAK_DECAY_CYCLES = 200
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic [2:0]          live_cnt,
   output logic [BAR_SEGS-1:0] pk_mask
);

   localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(PEAK_HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] DECAY_LD = TMR_W'(PEAK_DECAY_CYCLES - 1);

   logic [2:0]       pk_d, pk_q;
   logic [TMR_W-1:0] tmr_d, tmr_q;

   always_comb begin
      pk_d  = pk_q;
      tmr_d = tmr_q;
      if (clr) begin
         pk_d  = '0;
         tmr_d = '0;
      end else if (live_cnt >= pk_q) begin
         pk_d  = live_cnt;
         tmr_d = HOLD_LD;
      end else if (tmr_q != '0) begin
         tmr_d = tmr_q - TMR_W'(1);
      end else begin
         pk_d  = pk_q - 3'd1;
         tmr_d = DECAY_LD;
      end
   end

   // The displayed marker follows the registered peak, one segment lit at pk-1.
   always_comb begin
      pk_mask = '0;
      for (int k = 0; k < BAR_SEGS; k++) begin
         pk_mask[k] = (pk_q == 3'(k + 1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pk_q  <= '0;
         tmr_q <= '0;
      end else begin
         pk_q  <= pk_d;
         tmr_q <= tmr_d;
      end
   end

endmodule

// File: rtl/rpm_led_driver.sv
// Board LED driver: stage FSM with hysteresis, blinking red in DANGER,
// peak-hold bar and a sticky over-rev flag, two cycles from input to LEDs.
module rpm_led_driver
   import rpm_disp_pkg::*;
#(
   parameter int unsigned BLINK_HALF_CYCLES = 250,
   parameter int unsigned PEAK_HOLD_CYCLES  = 1000,
   parameter int unsigned PEAK_DECAY_CYCLES = 200,
   parameter int unsigned OVERREV_CYCLES    = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] speed_level,
   input  logic [3:0] max_level,
   output logic [7:0] leds,
   output logic [1:0] rpm_stage,
   output logic       overrev
);

   localparam logic [TMR_W-1:0] BLINK_LD = TMR_W'(BLINK_HALF_CYCLES - 1);
   localparam logic [TMR_W-1:0] OREV_LD  = TMR_W'(OVERREV_CYCLES - 1);

   function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
      return (&v) ? v : v + TMR_W'(1);
   endfunction

   logic [3:0]          s_p1_d, s_p1_q, m_p1_d, m_p1_q, m_p2_d, m_p2_q;
   stage_e              stage_d, stage_q;
   logic [TMR_W-1:0]    blink_cnt_d, blink_cnt_q, orev_cnt_d, orev_cnt_q;
   logic                blink_on_d, blink_on_q, overrev_d, overrev_q;
   logic [7:0]          leds_p2_d, leds_p2_q;
   logic [BAR_SEGS-1:0] live, pk_mask, bar;
   logic [2:0]          live_cnt, rgb;
   logic [3:0]          h;
   logic [4:0]          s_inc;
   logic                gear_chg, no_gear;

   // ---- stage 1: input capture; m_p2 keeps the previous gear for change detect
   always_comb begin
      s_p1_d = speed_level;
      m_p1_d = max_level;
      m_p2_d = m_p1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_p1_q <= '0;
         m_p1_q <= '0;
         m_p2_q <= '0;
      end else begin
         s_p1_q <= s_p1_d;
         m_p1_q <= m_p1_d;
         m_p2_q <= m_p2_d;
      end
   end

   // ---- stage 2: decode, stage FSM, blink, over-rev, output registers
   always_comb begin
      live     = live_bar(s_p1_q, m_p1_q);
      live_cnt = seg_count(live);
      h        = m_p1_q >> 1;
      s_inc    = {1'b0, s_p1_q} + 5'd1;
      no_gear  = (m_p1_q == 4'd0);
      gear_chg = (m_p1_q != m_p2_q);
   end

   rpm_peak_hold #(
      .PEAK_HOLD_CYCLES  (PEAK_HOLD_CYCLES),
      .PEAK_DECAY_CYCLES (PEAK_DECAY_CYCLES)
   ) u_peak (
      .clk      (clk),
      .rst      (rst),
      .clr      (gear_chg | no_gear),
      .live_cnt (live_cnt),
      .pk_mask  (pk_mask)
   );

   always_comb begin
      stage_d = stage_q;
      if (no_gear) begin
         stage_d = NORMAL;
      end else if (s_p1_q >= m_p1_q) begin
         stage_d = DANGER;
      end else begin
         case (stage_q)
            NORMAL:  if (s_p1_q >= h) stage_d = CAUTION;
            CAUTION: if (s_inc < {1'b0, h}) stage_d = NORMAL;
            DANGER:  if (s_inc < {1'b0, m_p1_q}) stage_d = (s_p1_q >= h) ? CAUTION : NORMAL;
            default: stage_d = NORMAL;
         endcase
      end
   end

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      orev_cnt_d  = '0;
      overrev_d   = overrev_q;
      rgb         = GREEN;

      // Leaving DANGER parks the blink at "on" so the next entry starts lit.
      if (stage_d != DANGER || stage_q != DANGER) begin
         blink_cnt_d = '0;
         blink_on_d  = 1'b1;
      end else if (blink_cnt_q == BLINK_LD) begin
         blink_cnt_d = '0;
         blink_on_d  = ~blink_on_q;
      end else begin
         blink_cnt_d = blink_cnt_q + TMR_W'(1);
      end

      if (stage_d == DANGER && stage_q == DANGER) begin
         orev_cnt_d = sat_inc(orev_cnt_q);
      end

      if (stage_d == NORMAL) begin
         overrev_d = 1'b0;
      end else if (stage_d == DANGER && orev_cnt_d >= OREV_LD) begin
         overrev_d = 1'b1;
      end

      case (stage_d)
         CAUTION: rgb = YELLOW;
         DANGER:  rgb = blink_on_d ? RED : OFF;
         default: rgb = GREEN;
      endcase

      bar       = live | pk_mask;
      leds_p2_d = no_gear ? 8'h00 : {rgb, bar};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q     <= NORMAL;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         orev_cnt_q  <= '0;
         overrev_q   <= 1'b0;
         leds_p2_q   <= '0;
      end else begin
         stage_q     <= stage_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         orev_cnt_q  <= orev_cnt_d;
         overrev_q   <= overrev_d;
         leds_p2_q   <= leds_p2_d;
      end
   end

   assign leds      = leds_p2_q;
   assign rpm_stage = stage_q;
   assign overrev   = overrev_q;

endmodule

// File: tb/tb_rpm_led_driver.sv
// Testbench for rpm_led_driver: per-cycle comparison against a behavioural
// model plus directed literal checks of the LED pattern.
module tb_rpm_led_driver;

   localparam int HALF  = 250;
   localparam int HOLD  = 1000;
   localparam int DECAY = 200;
   localparam int OREV  = 2000;

   logic       clk;
   logic       rst;
   logic [3:0] spd, mx;
   logic [7:0] leds;
   logic [1:0] rpm_stage;
   logic       overrev;

   int checks   = 0;
   int failures = 0;

   rpm_led_driver #(
      .BLINK_HALF_CYCLES (HALF),
      .PEAK_HOLD_CYCLES  (HOLD),
      .PEAK_DECAY_CYCLES (DECAY),
      .OVERREV_CYCLES    (OREV)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .speed_level (spd),
      .max_level   (mx),
      .leds        (leds),
      .rpm_stage   (rpm_stage),
      .overrev     (overrev)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   function automatic int live_cnt(int s, int m);
      int n;
      if (s == 0) return 0;
      n = 1;
      for (int k = 1; k < 5; k++) if (5 * s >= k * m) n++;
      return n;
   endfunction

   // Peak value e cycles after it was last loaded with v.
   function automatic int pk_at(int v, int e);
      int r;
      if (e < HOLD) return v;
      r = v - 1 - (e - HOLD) / DECAY;
      return (r < 0) ? 0 : r;
   endfunction

   int         ms1, mm1, mm2, mstage, mrun, mv, me;
   bit         movr;
   bit         chk_en = 1'b0;
   logic [7:0] exp_leds;
   logic [1:0] exp_stage;
   logic       exp_ovr;

   initial begin : model_proc
      int         s, m, h, l, cur, ns, barv;
      logic [2:0] rgb;
      logic [4:0] bar5;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            checks++;
            if (leds !== exp_leds) begin
               failures++;
               $display("FAIL model_leds t=%0t got=%b exp=%b", $time, leds, exp_leds);
            end
            checks++;
            if (rpm_stage !== exp_stage) begin
               failures++;
               $display("FAIL model_stage t=%0t got=%0d exp=%0d", $time, rpm_stage, exp_stage);
            end
            checks++;
            if (overrev !== exp_ovr) begin
               failures++;
               $display("FAIL model_overrev t=%0t got=%b exp=%b", $time, overrev, exp_ovr);
            end
         end
         if (rst) begin
            ms1 = 0; mm1 = 0; mm2 = 0; mstage = 0; mrun = 0; mv = 0; me = 0; movr = 0;
            exp_leds = 8'h00; exp_stage = 2'd0; exp_ovr = 1'b0;
            chk_en = 1'b1;
         end else begin
            s   = ms1;
            m   = mm1;
            h   = m / 2;
            l   = live_cnt(s, m);
            cur = pk_at(mv, me);
            if (m != mm2 || m == 0) begin
               mv = 0; me = 0;
            end else if (l >= cur) begin
               mv = l; me = 0;
            end else begin
               me++;
            end
            if (m == 0)           ns = 0;
            else if (s >= m)      ns = 2;
            else if (mstage == 0) ns = (s >= h) ? 1 : 0;
            else if (mstage == 2) ns = (s + 1 < m) ? ((s >= h) ? 1 : 0) : 2;
            else                  ns = (s + 1 < h) ? 0 : 1;
            mrun = (ns == 2 && mstage == 2) ? mrun + 1 : 0;
            if (ns == 0) movr = 0;
            else if (ns == 2 && mrun >= OREV - 1) movr = 1;
            rgb  = (ns == 0) ? 3'b010 : (ns == 1) ? 3'b110 :
                   (((mrun / HALF) % 2) == 0) ? 3'b100 : 3'b000;
            barv = ((1 << l) - 1) | ((cur > 0) ? (1 << (cur - 1)) : 0);
            bar5 = barv[4:0];
            exp_leds  = (m == 0) ? 8'h00 : {rgb, bar5};
            exp_stage = 2'(ns);
            exp_ovr   = movr;
            mstage    = ns;
            mm2 = mm1;
            ms1 = int'(spd);
            mm1 = int'(mx);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
      end
   endtask

   initial begin
      rst = 1'b1; spd = 4'd0; mx = 4'd0;
      step(2);
      chk("reset_leds", leds, 8'h00);
      chk("reset_stage", 8'(rpm_stage), 8'd0);
      chk("reset_overrev", 8'(overrev), 8'd0);
      rst = 1'b0;

      mx = 4'd8; spd = 4'd4;
      step(2);
      chk("caution_leds", leds, 8'b110_00111);
      chk("caution_stage", 8'(rpm_stage), 8'd1);
      chk("caution_overrev", 8'(overrev), 8'd0);

      spd = 4'd8;
      step(2);
      chk("blink_on_first", leds, 8'b100_11111);
      chk("danger_stage", 8'(rpm_stage), 8'd2);
      step(HALF - 1);
      chk("blink_on_last", leds, 8'b100_11111);
      step(1);
      chk("blink_off_first", leds, 8'b000_11111);
      step(HALF - 1);
      chk("blink_off_last", leds, 8'b000_11111);
      step(1);
      chk("blink_on_again", leds, 8'b100_11111);

      spd = 4'd7;
      step(2);
      chk("s7_still_danger", 8'(rpm_stage), 8'd2);
      spd = 4'd6;
      step(2);
      chk("s6_peak_held", leds, 8'b110_11111);
      step(1100);
      chk("s6_after_decay", leds, 8'b110_01111);

      spd = 4'd8;
      step(10);
      spd = 4'd0;
      step(2);
      chk("drop_first", leds, 8'b010_10000);
      step(HOLD - 1);
      chk("hold_last", leds, 8'b010_10000);
      step(1);
      chk("decay_4", leds, 8'b010_01000);
      step(DECAY - 1);
      chk("decay_4_last", leds, 8'b010_01000);
      step(1);
      chk("decay_3", leds, 8'b010_00100);
      step(DECAY);
      chk("decay_2", leds, 8'b010_00010);
      step(DECAY);
      chk("decay_1", leds, 8'b010_00001);
      step(DECAY);
      chk("decay_0", leds, 8'b010_00000);

      spd = 4'd8;
      step(2);
      chk("orev_start", 8'(overrev), 8'd0);
      step(OREV - 2);
      chk("orev_before", 8'(overrev), 8'd0);
      step(1);
      chk("orev_set", 8'(overrev), 8'd1);
      spd = 4'd5;
      step(2);
      chk("orev_caution_stage", 8'(rpm_stage), 8'd1);
      chk("orev_sticky", 8'(overrev), 8'd1);
      spd = 4'd1;
      step(2);
      chk("orev_normal_stage", 8'(rpm_stage), 8'd0);
      chk("orev_cleared", 8'(overrev), 8'd0);

      spd = 4'd8;
      step(5);
      mx = 4'd4; spd = 4'd0;
      step(3);
      chk("gear_peak_clear", leds, 8'b010_00000);
      mx = 4'd0; spd = 4'd9;
      step(2);
      chk("neutral_leds", leds, 8'h00);
      chk("neutral_stage", 8'(rpm_stage), 8'd0);

      mx = 4'd8; spd = 4'd8;
      step(300);
      rst = 1'b1;
      step(1);
      chk("rst_mid_leds", leds, 8'h00);
      chk("rst_mid_overrev", 8'(overrev), 8'd0);
      rst = 1'b0; spd = 4'd0;
      step(2);
      chk("after_rst_leds", leds, 8'b010_00000);

      mx = 4'd1; spd = 4'd0;
      step(2);
      chk("m1_caution", leds, 8'b110_00000);
      spd = 4'd1;
      step(2);
      chk("m1_danger", leds, 8'b100_11111);

      step(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
